// File: rtl/uart_rx_ll.sv
// Low-level 8N1 UART receiver with a one-byte valid/ready holding register.
// Optional even-parity support is compiled in when PARITY_EN is defined.
module uart_rx_ll #(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned BAUD_RATE   = 115_200
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rx_in,
   output logic [7:0] ll_byte_out,
   output logic       ll_valid_out,
   input  logic       ll_ready_in,
   output logic       busy_out,
   output logic       framing_err_out,
   output logic       overrun_err_out,
   output logic       parity_err_out
);

   localparam int unsigned BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
   localparam int unsigned CW       = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] C_FULL = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] C_HALF = CW'(BAUD_DIV / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t          r_state, w_state_nxt;
   logic            r_rx_meta, r_rx_s, r_rx_hist;
   logic [1:0]      r_warm;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [7:0]      r_shift, w_shift_nxt;
   logic [2:0]      r_bit, w_bit_nxt;
   logic            w_byte_done, w_frame_err;
   logic [7:0]      r_byte;
   logic            r_valid, r_frame_err, r_overrun_err;

   // History only tracks rx_s once the synchronizer holds real line samples,
   // so a line held low across reset never looks like a falling edge.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_hist <= 1'b0;
         r_warm    <= '0;
      end else begin
         r_rx_meta <= rx_in;
         r_rx_s    <= r_rx_meta;
         r_rx_hist <= r_warm[1] & r_rx_s;
         r_warm    <= {r_warm[0], 1'b1};
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
         r_bit   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_shift <= w_shift_nxt;
         r_bit   <= w_bit_nxt;
      end
   end

`ifdef PARITY_EN
   logic r_par_bad, w_par_bad_nxt, w_par_err, r_parity_err;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         r_par_bad    <= w_par_bad_nxt;
         r_parity_err <= w_par_err;
      end
   end

   assign parity_err_out = r_parity_err;
`else
   assign parity_err_out = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_bit_nxt   = r_bit;
      w_byte_done = 1'b0;
      w_frame_err = 1'b0;
`ifdef PARITY_EN
      w_par_bad_nxt = r_par_bad;
      w_par_err     = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (r_rx_hist && !r_rx_s) begin
               w_cnt_nxt   = C_HALF;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CW'(1);
            end else if (!r_rx_s) begin
               w_cnt_nxt   = C_FULL;
               w_bit_nxt   = '0;
               w_state_nxt = S_DATA;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_DATA: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CW'(1);
            end else begin
               w_shift_nxt = {r_rx_s, r_shift[7:1]};
               w_cnt_nxt   = C_FULL;
               w_bit_nxt   = r_bit + 3'd1;
               if (r_bit == 3'd7) begin
`ifdef PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end
            end
         end
`ifdef PARITY_EN
         S_PARITY: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CW'(1);
            end else begin
               w_par_bad_nxt = ^{r_shift, r_rx_s};
               w_cnt_nxt     = C_FULL;
               w_state_nxt   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CW'(1);
            end else begin
               w_frame_err = !r_rx_s;
`ifdef PARITY_EN
               w_par_err   = r_par_bad;
               w_byte_done = r_rx_s && !r_par_bad;
`else
               w_byte_done = r_rx_s;
`endif
               w_state_nxt = r_rx_s ? S_IDLE : S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: begin
            if (r_rx_s) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Simultaneous accept and completion hands over without an overrun.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_byte        <= '0;
         r_valid       <= 1'b0;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         r_frame_err   <= w_frame_err;
         r_overrun_err <= 1'b0;
         if (w_byte_done) begin
            if (!r_valid || ll_ready_in) begin
               r_byte  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_overrun_err <= 1'b1;
            end
         end else if (r_valid && ll_ready_in) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign ll_byte_out     = r_byte;
   assign ll_valid_out    = r_valid;
   assign busy_out        = (r_state != S_IDLE);
   assign framing_err_out = r_frame_err;
   assign overrun_err_out = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_ll.sv
// Directed self-checking bench for uart_rx_ll at BAUD_DIV = 10.
// Define PARITY_EN for both files to exercise the parity variant.
module tb_uart_rx_ll;

   localparam int BD = 10;
`ifdef PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int LAT = 2 + BD/2 + 9*BD + 1 + (PAR ? BD : 0);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] ll_byte;
   logic       ll_valid, busy, ferr, oerr, perr;

   uart_rx_ll #(.CLK_FREQ_HZ(100_000_000), .BAUD_RATE(10_000_000)) dut (
      .clk_in(clk), .rst_in(rst), .rx_in(rx),
      .ll_byte_out(ll_byte), .ll_valid_out(ll_valid), .ll_ready_in(ready),
      .busy_out(busy), .framing_err_out(ferr), .overrun_err_out(oerr),
      .parity_err_out(perr));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] rx_log[$];
   int n_ferr = 0, n_oerr = 0, n_perr = 0, n_vcyc = 0, n_unstable = 0;
   int rise_cyc = 0, low_run = 0, max_low = 0;
   bit in_burst = 1'b0;
   logic prev_v = 1'b0;
   logic [7:0] prev_b = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (ll_valid && ready) rx_log.push_back(ll_byte);
         if (ll_valid && !prev_v) rise_cyc = cyc;
         if (prev_v && ll_valid && ll_byte !== prev_b) n_unstable++;
         if (ll_valid) n_vcyc++;
         if (ferr) n_ferr++;
         if (oerr) n_oerr++;
         if (perr) n_perr++;
         if (in_burst) begin
            if (!busy) begin
               low_run++;
               if (low_run > max_low) max_low = low_run;
            end else low_run = 0;
         end
      end
      prev_v = ll_valid;
      prev_b = ll_byte;
   end

   int n_tests = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bit_out(input logic v);
      rx = v;
      repeat (BD) @(posedge clk);
      #1;
   endtask

   int t_start = 0;

   // Caller must be at posedge+1; frames chain with no idle gap.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
      t_start = cyc;
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
      if (PAR) bit_out((^b) ^ par_flip);
      bit_out(stop);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_bytes(input int target, input int budget);
      int k = 0;
      while (rx_log.size() < target && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd, f0, o0, p0, v0, lat;
      logic [7:0] seq[5];
      seq = '{8'hFA, 8'hFA, 8'hFA, 8'hFA, 8'hEF};

      repeat (3) @(posedge clk);
      #1;
      check("rst_byte", ll_byte, 8'h00);
      check("rst_valid", ll_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ferr", ferr, 1'b0);
      check("rst_oerr", oerr, 1'b0);
      check("rst_perr", perr, 1'b0);
      rst = 1'b0;
      idle(10);

      // 1: single byte, latency, one-cycle valid
      rd = rx_log.size(); f0 = n_ferr; o0 = n_oerr; p0 = n_perr; v0 = n_vcyc;
      send_frame(8'hFA, 1'b1, 1'b0);
      wait_bytes(rd + 1, 40);
      idle(10);
      check("t1_count", rx_log.size() - rd, 1);
      if (rx_log.size() > rd) check("t1_byte", rx_log[rd], 8'hFA);
      lat = rise_cyc - t_start;
      check("t1_latency_in_window", (lat >= LAT - 1 && lat <= LAT + 1), 1'b1);
      check("t1_valid_cycles", n_vcyc - v0, 1);
      check("t1_errs", (n_ferr - f0) + (n_oerr - o0) + (n_perr - p0), 0);

      // 2: back-to-back burst
      rd = rx_log.size(); f0 = n_ferr; o0 = n_oerr;
      in_burst = 1'b1;
      for (int i = 0; i < 5; i++) send_frame(seq[i], 1'b1, 1'b0);
      in_burst = 1'b0;
      wait_bytes(rd + 5, 40);
      check("t2_count", rx_log.size() - rd, 5);
      for (int i = 0; i < 5; i++)
         if (rx_log.size() > rd + i) check($sformatf("t2_byte%0d", i), rx_log[rd + i], seq[i]);
      check("t2_busy_gap_le_bit", (max_low <= BD), 1'b1);
      check("t2_errs", (n_ferr - f0) + (n_oerr - o0), 0);
      idle(20);

      // 3: stall, overrun, then release
      rd = rx_log.size(); o0 = n_oerr;
      ready = 1'b0;
      send_frame(8'h01, 1'b1, 1'b0);
      send_frame(8'h23, 1'b1, 1'b0);
      idle(5);
      check("t3_valid_held", ll_valid, 1'b1);
      check("t3_byte_held", ll_byte, 8'h01);
      check("t3_overrun_pulses", n_oerr - o0, 1);
      check("t3_none_accepted", rx_log.size() - rd, 0);
      ready = 1'b1;
      idle(3);
      check("t3_accepted", rx_log.size() - rd, 1);
      if (rx_log.size() > rd) check("t3_acc_byte", rx_log[rd], 8'h01);
      check("t3_valid_drop", ll_valid, 1'b0);
      idle(20);
      check("t3_second_dropped", rx_log.size() - rd, 1);

      // 4: framing error, long low, recovery
      rd = rx_log.size(); f0 = n_ferr;
      send_frame(8'h55, 1'b0, 1'b0);
      rx = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("t4_busy_while_low", busy, 1'b1);
      check("t4_ferr_pulses", n_ferr - f0, 1);
      check("t4_no_byte", rx_log.size() - rd, 0);
      idle(20);
      send_frame(8'hBC, 1'b1, 1'b0);
      wait_bytes(rd + 1, 40);
      check("t4_recover_count", rx_log.size() - rd, 1);
      if (rx_log.size() > rd) check("t4_recover_byte", rx_log[rd], 8'hBC);
      check("t4_ferr_total", n_ferr - f0, 1);
      idle(20);

      // 5a: short glitch
      rd = rx_log.size(); f0 = n_ferr; o0 = n_oerr; v0 = n_vcyc;
      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      idle(30);
      check("t5_glitch_busy", busy, 1'b0);
      check("t5_glitch_valid", n_vcyc - v0, 0);
      check("t5_glitch_errs", (n_ferr - f0) + (n_oerr - o0), 0);

      // 5b: reset after bit 3 of 0x0F, released while line is low
      p0 = n_perr;
      bit_out(1'b0);
      for (int i = 0; i < 4; i++) bit_out(1'b1);
      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("t5_rst_busy", busy, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (BD * 3 + 7) @(posedge clk);
      #1;
      bit_out(1'b1);
      idle(30);
      check("t5_rst_no_byte", rx_log.size() - rd, 0);
      check("t5_rst_no_errs", (n_ferr - f0) + (n_oerr - o0) + (n_perr - p0), 0);
      send_frame(8'h10, 1'b1, 1'b0);
      wait_bytes(rd + 1, 40);
      check("t5_after_count", rx_log.size() - rd, 1);
      if (rx_log.size() > rd) check("t5_after_byte", rx_log[rd], 8'h10);
      idle(20);

`ifdef PARITY_EN
      // 6: parity good then bad
      rd = rx_log.size(); p0 = n_perr; f0 = n_ferr; v0 = n_vcyc;
      send_frame(8'h7E, 1'b1, 1'b0);
      wait_bytes(rd + 1, 40);
      idle(10);
      check("t6_good_count", rx_log.size() - rd, 1);
      if (rx_log.size() > rd) check("t6_good_byte", rx_log[rd], 8'h7E);
      v0 = n_vcyc;
      send_frame(8'h7E, 1'b1, 1'b1);
      idle(20);
      check("t6_bad_perr", n_perr - p0, 1);
      check("t6_bad_no_valid", n_vcyc - v0, 0);
      check("t6_ferr", n_ferr - f0, 0);
`else
      check("perr_tied_low", n_perr, 0);
`endif

      check("byte_stable_while_valid", n_unstable, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
